// File: rtl/neurocore_pkg.sv
// neurocore_pkg: shared types and helpers for the AER output path.
//   aer_state_e   scan FSM state encoding (IDLE, HDR, TS)
//   AER_HDR_MARK  value of bit 7 in every header byte
//   TS_W          timestamp width in bits
//   lsb_index()   index of the lowest set bit of a vector of up to 128 bits
package neurocore_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_TS   = 2'd2
   } aer_state_e;

   localparam logic AER_HDR_MARK = 1'b1;
   localparam int   TS_W         = 8;

   // The scan runs from the top bit down so the lowest set bit is the last
   // one written. An all-zero vector returns 0.
   function automatic logic [6:0] lsb_index(input logic [127:0] v);
      logic [6:0] idx;
      idx = '0;
      for (int i = 127; i >= 0; i--) begin
         if (v[i]) idx = 7'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO holding queued timesteps.
//   clk    rising-edge clock
//   rst    synchronous active-high reset; empties the FIFO
//   push   write request; accepted when not full, or when a pop happens in
//          the same cycle
//   pop    read request; ignored when empty
//   din    write data
//   dout   head entry (valid while empty=0)
//   full   count == DEPTH
//   empty  count == 0
module spike_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   // When full, a same-cycle pop frees the slot at rd_ptr, which is exactly
   // where wr_ptr points, so the write lands in the slot being vacated.
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/aer_spike_encoder.sv
// aer_spike_encoder: turns per-timestep spike vectors into an AER byte stream.
//   clk        rising-edge clock
//   rst        synchronous active-high reset; abandons the current event and
//              flushes the queue
//   tick       timestep strobe; spike_vec is sampled only while tick=1
//   spike_vec  spikes for the current timestep
//   out_data   event byte: header {1, addr[6:0]}, then (optionally) timestamp
//   out_valid  out_data valid; held with out_data until out_ready
//   out_ready  consumer accepts the byte when out_valid=1
//   overflow   sticky; a non-zero timestep was dropped because the queue was full
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   busy       queue non-empty or scan FSM active
// Build option AER_TIMESTAMP_EN: when defined each event is a header byte
// followed by the 8-bit timestep; when undefined each event is the header only
// and no timestamp state exists.
//
// state | meaning
// IDLE  | waiting for a queued timestep; loads head entry into work_vec
// HDR   | presenting header byte for lowest set bit of work_vec
// TS    | presenting timestamp byte (AER_TIMESTAMP_EN only)
module aer_spike_encoder
   import neurocore_pkg::*;
#(
   parameter int N_NEURONS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic [N_NEURONS-1:0] spike_vec,
   output logic [7:0]           out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 overflow,
   input  logic                 ovf_clr,
   output logic                 busy
);

`ifdef AER_TIMESTAMP_EN
   localparam int FW = TS_W + N_NEURONS;
`else
   localparam int FW = N_NEURONS;
`endif

   logic [FW-1:0]        fifo_din;
   logic [FW-1:0]        fifo_dout;
   logic                 push_req;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 drop;
   logic                 hs;
   logic                 last;

   aer_state_e           state;
   logic [N_NEURONS-1:0] work_vec;
   logic [N_NEURONS-1:0] head_vec;
   logic [N_NEURONS-1:0] next_vec;
   logic [N_NEURONS-1:0] one_hot;
   logic [6:0]           cur_addr;
   logic [6:0]           head_addr;
   logic [6:0]           next_addr;

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0]      ts_cnt;
   logic [TS_W-1:0]      head_ts;
   logic [TS_W-1:0]      cur_ts;

   assign fifo_din            = {ts_cnt, spike_vec};
   assign {head_ts, head_vec} = fifo_dout;
`else
   assign fifo_din            = spike_vec;
   assign head_vec            = fifo_dout;
`endif

   assign push_req  = tick & (spike_vec != '0);
   assign drop      = push_req & full & ~pop;
   assign hs        = out_valid & out_ready;
   assign one_hot   = {{(N_NEURONS-1){1'b0}}, 1'b1};
   assign next_vec  = work_vec & ~(one_hot << cur_addr);
   assign last      = (next_vec == '0);
   assign head_addr = lsb_index(128'(head_vec));
   assign next_addr = lsb_index(128'(next_vec));

   // The head entry stays in the FIFO until its final byte is accepted, so
   // the queue occupancy counts the event being emitted.
`ifdef AER_TIMESTAMP_EN
   assign pop = (state == ST_TS) & hs & last;
`else
   assign pop = (state == ST_HDR) & hs & last;
`endif

   assign busy = ~empty | (state != ST_IDLE);

   spike_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

`ifdef AER_TIMESTAMP_EN
   always_ff @(posedge clk) begin
      if (rst)       ts_cnt <= '0;
      else if (tick) ts_cnt <= ts_cnt + TS_W'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst)          overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         work_vec  <= '0;
         cur_addr  <= '0;
`ifdef AER_TIMESTAMP_EN
         cur_ts    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  work_vec  <= head_vec;
                  cur_addr  <= head_addr;
`ifdef AER_TIMESTAMP_EN
                  cur_ts    <= head_ts;
`endif
                  out_data  <= {AER_HDR_MARK, head_addr};
                  out_valid <= 1'b1;
                  state     <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (hs) begin
`ifdef AER_TIMESTAMP_EN
                  out_data <= cur_ts;
                  state    <= ST_TS;
`else
                  work_vec <= next_vec;
                  if (last) begin
                     out_valid <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     cur_addr <= next_addr;
                     out_data <= {AER_HDR_MARK, next_addr};
                  end
`endif
               end
            end
`ifdef AER_TIMESTAMP_EN
            ST_TS: begin
               if (hs) begin
                  work_vec <= next_vec;
                  if (last) begin
                     out_valid <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     cur_addr <= next_addr;
                     out_data <= {AER_HDR_MARK, next_addr};
                     state    <= ST_HDR;
                  end
               end
            end
`endif
            default: begin
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Bench for aer_spike_encoder. Honours AER_TIMESTAMP_EN the same way the
// design does: with it defined each event is header + timestamp byte.
module tb_aer_spike_encoder;

   localparam int N = 8;
   localparam int D = 4;
`ifdef AER_TIMESTAMP_EN
   localparam int BPE = 2;
`else
   localparam int BPE = 1;
`endif

   typedef byte unsigned bq_t[$];

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic [N-1:0] spike_vec;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready;
   logic         overflow;
   logic         ovf_clr;
   logic         busy;

   int checks = 0;
   int errors = 0;

   // Model state: expected byte stream, bytes remaining per queued timestep,
   // sticky overflow and timestep counter.
   bq_t          exp_q;
   int           ent_q[$];
   bit           m_ovf;
   int           m_ts;
   int           nb;
   bit           started = 0;
   bit           rst_q   = 0;
   bq_t          got_q;
   bit           prev_stall = 0;
   logic [7:0]   prev_data;

   always #5 clk = ~clk;

   aer_spike_encoder #(.N_NEURONS(N), .FIFO_DEPTH(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .spike_vec (spike_vec),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr),
      .busy      (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model update at the sampling edge.
   always @(posedge clk) begin
      rst_q = rst;
      if (rst) begin
         started = 1;
         exp_q.delete();
         ent_q.delete();
         m_ovf = 0;
         m_ts  = 0;
      end else if (started) begin
         if (tick && spike_vec != '0 && ent_q.size() >= D) begin
            m_ovf = 1;
         end else begin
            if (tick && spike_vec != '0) begin
               nb = 0;
               for (int i = 0; i < N; i++) begin
                  if (spike_vec[i]) begin
                     exp_q.push_back(8'(128 + i));
`ifdef AER_TIMESTAMP_EN
                     exp_q.push_back(8'(m_ts));
`endif
                     nb = nb + BPE;
                  end
               end
               ent_q.push_back(nb);
            end
            if (ovf_clr) m_ovf = 0;
         end
         if (tick) m_ts = (m_ts + 1) % 256;
      end
   end

   // Per-cycle comparison on the falling edge.
   always @(negedge clk) begin
      if (started) begin
         chk("busy", int'(busy), int'(ent_q.size() != 0));
         chk("overflow", int'(overflow), int'(m_ovf));
         if (ent_q.size() == 0) chk("idle_valid", int'(out_valid), 0);
         if (!rst_q && prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(prev_data));
         end
         if (out_valid === 1'b1 && out_ready && !rst) begin
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stream: got 0x%0h expected no byte", out_data);
            end else begin
               chk("stream", int'(out_data), int'(exp_q.pop_front()));
            end
            if (ent_q.size() != 0) begin
               ent_q[0] = ent_q[0] - 1;
               if (ent_q[0] == 0) void'(ent_q.pop_front());
            end
         end
         prev_stall = (out_valid === 1'b1) && !out_ready && !rst;
         prev_data  = out_data;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic [N-1:0] v);
      tick      = 1'b1;
      spike_vec = v;
      step();
      tick      = 1'b0;
      spike_vec = '0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      step();
      step();
      rst       = 1'b0;
   endtask

   task automatic wait_idle(input string name, output int cyc);
      cyc = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && cyc < 500) begin
         step();
         cyc++;
      end
      if (cyc >= 500) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy=%0b expected 0 within 500 cycles", name, busy);
      end
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got out_valid=%0b expected 1 within 50 cycles", name, out_valid);
      end
   endtask

   task automatic check_got(input string name, input bq_t e);
      chk({name, "_len"}, got_q.size(), e.size());
      for (int i = 0; i < e.size() && i < got_q.size(); i++)
         chk($sformatf("%s_b%0d", name, i), int'(got_q[i]), int'(e[i]));
      got_q.delete();
   endtask

   initial begin
      bq_t e;
      int  cyc;
      rst = 1'b1; tick = 1'b0; spike_vec = '0; out_ready = 1'b0; ovf_clr = 1'b0;

      // 1: reset with tick toggling
      tick = 1'b1; spike_vec = 8'hFF; step();
      tick = 1'b0; spike_vec = '0;   step();
      rst = 1'b0;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_data", int'(out_data), 0);

      // 2: basic event at ts 0
      out_ready = 1'b1;
      do_tick(8'h05);
      wait_idle("basic", cyc);
      chk("basic_latency", cyc, 1 + 2 * BPE);
`ifdef AER_TIMESTAMP_EN
      e = {8'h80, 8'h00, 8'h82, 8'h00};
`else
      e = {8'h80, 8'h82};
`endif
      check_got("basic", e);

      // 3: timestamp advance
      do_reset();
      out_ready = 1'b1;
      do_tick(8'h00); do_tick(8'h00); do_tick(8'h00);
      do_tick(8'h80);
      wait_idle("tsadv", cyc);
`ifdef AER_TIMESTAMP_EN
      e = {8'h87, 8'h03};
`else
      e = {8'h87};
`endif
      check_got("tsadv", e);

      // 4: backpressure mid-HDR (ts 4)
      out_ready = 1'b0;
      do_tick(8'h02);
      wait_valid("bp");
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_data", int'(out_data), 8'h81);
         step();
      end
      out_ready = 1'b1;
      wait_idle("bp", cyc);
`ifdef AER_TIMESTAMP_EN
      e = {8'h81, 8'h04};
`else
      e = {8'h81};
`endif
      check_got("bp", e);

      // 5: overflow, drain, clear, then set-wins-over-clear
      do_reset();
      for (int i = 0; i < 5; i++) do_tick(8'h01);
      chk("ovf_set", int'(overflow), 1);
      out_ready = 1'b1;
      wait_idle("ovf", cyc);
      e = {};
      for (int i = 0; i < 4; i++) begin
         e.push_back(8'h80);
`ifdef AER_TIMESTAMP_EN
         e.push_back(8'(i));
`endif
      end
      check_got("ovf_drain", e);
      chk("ovf_kept", int'(overflow), 1);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      chk("ovf_clr", int'(overflow), 0);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_tick(8'h01);
      ovf_clr = 1'b1; do_tick(8'h01); ovf_clr = 1'b0;
      chk("ovf_setwins", int'(overflow), 1);
      out_ready = 1'b1;
      wait_idle("ovf2", cyc);
      e = {};
      for (int i = 5; i < 9; i++) begin
         e.push_back(8'h80);
`ifdef AER_TIMESTAMP_EN
         e.push_back(8'(i));
`endif
      end
      check_got("ovf2_drain", e);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

      // 6a: timestamp wrap
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) do_tick(8'h00);
      do_tick(8'h02);
      wait_idle("wrap", cyc);
`ifdef AER_TIMESTAMP_EN
      e = {8'h81, 8'h00};
`else
      e = {8'h81};
`endif
      check_got("wrap", e);

      // 6b: reset mid-event with 3 entries queued
      out_ready = 1'b0;
      do_tick(8'h03); do_tick(8'h03); do_tick(8'h03);
      wait_valid("mid");
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      rst       = 1'b1;
      step();
      chk("mid_valid", int'(out_valid), 0);
      chk("mid_busy", int'(busy), 0);
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("mid_busy_after", int'(busy), 0);
      e = {8'h80};
      check_got("mid", e);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aer_spike_encoder.md
Name: aer_spike_encoder

Overview:
- Output-side counterpart of the NeuroCore stimulus path: converts per-timestep neuron spike vectors into a serial Address-Event Representation (AER) byte stream for the host.
- Each tick, a non-zero spike vector is queued together with its timestep.
- A scan FSM emits one event per set bit, lowest neuron index first, over a valid/ready byte handshake.
- Sits between the neuron array and the uo_out/uio output mux.

Parameters:
- N_NEURONS, 8: spike vector width; legal range 2..128.
- FIFO_DEPTH, 4: queued timesteps; power of two, 2..16.

Ports:
- clk, input, 1: single clock; all logic rising-edge.
- rst, input, 1: synchronous, active-high reset.
- tick, input, 1: timestep strobe, one clk wide.
- spike_vec, input, N_NEURONS: spikes for the current timestep; sampled only when tick=1.
- out_data, output, 8: event byte.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts the byte when out_valid and out_ready are both high.
- overflow, output, 1: sticky flag; a non-zero timestep was dropped.
- ovf_clr, input, 1: clears overflow.
- busy, output, 1: FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset values: out_valid=0, out_data=0, overflow=0, busy=0; timestamp counter=0; FIFO empty; FSM in IDLE.
- Timestamp counter (8 bit):
  - Increments on every tick and wraps 255->0.
  - The value stored with a vector is the counter value before the increment, so the first tick is ts 0.
- FIFO push:
  - On tick with spike_vec!=0, push {ts, spike_vec}.
  - tick with spike_vec==0 pushes nothing but still advances ts.
- FIFO full:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set next cycle.
  - If ovf_clr and a new drop occur in the same cycle, overflow stays 1 (set wins).
- FSM states: IDLE, HDR, TS.
  - IDLE: if the FIFO is non-empty, load head vector into work_vec and head ts into cur_ts, then go to HDR on the next cycle.
  - HDR:
    - out_valid=1; out_data = {1'b1, addr[6:0]}, where addr is the index of the lowest set bit of work_vec, zero-extended.
    - On handshake, go to TS.
  - TS:
    - out_valid=1; out_data=cur_ts.
    - On handshake, clear bit addr in work_vec.
    - If work_vec is now zero: pop the FIFO and go to IDLE. Otherwise go to HDR.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_valid never drops without a handshake, except on rst.
- Throughput: one byte per cycle under continuous out_ready, plus one IDLE cycle per timestep.
- Bit 7 of out_data marks header bytes. The timestamp byte may have bit 7 set; the framing is positional (header, then ts).
- Reset mid-event:
  - The partial event is abandoned and the FIFO is flushed.
  - out_valid=0 on the cycle after rst is sampled.
- Width rule: addr = $clog2(N_NEURONS) bits, zero-padded to 7 bits.

Optional Feature:
- Macro: AER_TIMESTAMP_EN.
- Defined: two-byte events (HDR then TS) as above.
- Undefined:
  - TS state, the ts FIFO field and cur_ts are removed.
  - Each event is the single header byte; HDR clears the bit on handshake and pops/advances directly.
  - The timestamp counter is still removed; header format is unchanged.

Decomposition:
- Package neurocore_pkg:
  - FSM state enum.
  - AER_HDR_MARK = 1'b1.
  - TS_W = 8.
  - Lowest-set-bit priority-encoder function.
- Sub-module spike_fifo: synchronous FIFO of width TS_W+N_NEURONS and depth FIFO_DEPTH, with push, pop, full, empty, same-cycle push+pop.

Test Plan:
1. Reset: hold rst 2 cycles with tick toggling -> out_valid=0, busy=0, overflow=0; first tick after release carries ts 0.
2. Basic event: out_ready=1, tick with spike_vec=0x05 at ts 0 -> byte stream 0x80, 0x00, 0x82, 0x00; busy drops after the last handshake plus one cycle.
3. Timestamp advance: three ticks with spike_vec=0, then spike_vec=0x80 -> 0x87, 0x03.
4. Backpressure: out_ready=0 for 5 cycles mid-HDR -> out_data and out_valid stable at 0x81; release -> 0x81, ts, with no byte lost or duplicated.
5. Overflow (FIFO_DEPTH=4): out_ready=0, five ticks with spike_vec=0x01 -> fifth dropped, overflow=1; drain yields ts 0..3 only; ovf_clr -> overflow=0.
6. Wrap and reset:
   - 256 zero ticks then spike_vec=0x02 -> 0x81, 0x00.
   - Assert rst during TS with 3 entries queued -> out_valid=0 next cycle, busy=0, no further bytes.
